// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 sequencer: state encoding, opcodes, memory
// access codes and the execute-stage dispatch helper.
package lc3_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM_IND   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_UPDATE_PC = 3'd6
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] MEM_RD   = 2'd0;
  localparam logic [1:0] MEM_WR   = 2'd1;
  localparam logic [1:0] MEM_IND  = 2'd2;
  localparam logic [1:0] MEM_IDLE = 2'd3;

  // Where EXECUTE goes next; unsupported opcodes retire as a NOP.
  function automatic state_e exec_next(input logic [3:0] op);
    state_e ns;
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_LEA:          ns = S_WRITEBACK;
      OP_LD, OP_LDR, OP_ST, OP_STR:            ns = S_MEM;
      OP_LDI, OP_STI:                          ns = S_MEM_IND;
      OP_BR, OP_JMP:                           ns = S_UPDATE_PC;
      OP_JSR, OP_RTI, OP_RES, OP_TRAP:         ns = S_UPDATE_PC;
      default:                                 ns = S_UPDATE_PC;
    endcase
    return ns;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/lc3_mem_watchdog.sv
// Wait-cycle counter for data memory accesses. expired_o is high during the
// TIMEOUT-th consecutive waiting cycle since the last clear.
module lc3_mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

  // Saturates at the expiry value so a stalled state cannot wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lc3_sequencer.sv
// Multi-cycle LC-3 sequencer: Moore FSM producing per-stage enables, memory
// access type, branch decision, data-access timeout flag and a retire count.
module lc3_sequencer
  import lc3_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      IR,
  input  logic [2:0]       psr,
  input  logic             complete_instr,
  input  logic             complete_data,
  output logic             enable_fetch,
  output logic             enable_decode,
  output logic             enable_execute,
  output logic             enable_writeback,
  output logic             enable_updatePC,
  output logic [1:0]       mem_state,
  output logic             br_taken,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       dbg_state
);

  // Handshake: complete_instr / complete_data are level "done" flags, only
  // sampled at the rising edge while waiting in FETCH / MEM_IND / MEM.
  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             br_taken_q, br_taken_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic wd_clear, wd_enable, wd_expired;
  logic unused_ir;

  assign unused_ir = ^IR[8:0];

  assign wd_enable = (state_q == S_MEM) || (state_q == S_MEM_IND);
  assign wd_clear  = ((state_d == S_MEM) || (state_d == S_MEM_IND)) && (state_d != state_q);

  lc3_mem_watchdog #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    br_taken_d = br_taken_q;
    mem_err_d  = mem_err_q;
    count_d    = count_q;
    case (state_q)
      S_FETCH: begin
        if (complete_instr) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = IR[15:12];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d    = exec_next(op_q);
        br_taken_d = (op_q == OP_BR) ? |(IR[11:9] & psr) : (op_q == OP_JMP);
      end
      S_MEM_IND: begin
        if (complete_data) begin
          state_d = S_MEM;
        end else if (wd_expired) begin
          mem_err_d = 1'b1;
          state_d   = S_UPDATE_PC;
        end
      end
      S_MEM: begin
        if (complete_data) begin
          state_d = is_store(op_q) ? S_UPDATE_PC : S_WRITEBACK;
        end else if (wd_expired) begin
          mem_err_d = 1'b1;
          state_d   = S_UPDATE_PC;
        end
      end
      S_WRITEBACK: begin
        state_d = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        count_d = count_q + CNT_W'(1);
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      op_q       <= 4'd0;
      br_taken_q <= 1'b0;
      mem_err_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      br_taken_q <= br_taken_d;
      mem_err_q  <= mem_err_d;
      count_q    <= count_d;
    end
  end

  // Enables are gated by reset so nothing fires while reset is held.
  assign enable_fetch     = !reset && (state_q == S_FETCH);
  assign enable_decode    = !reset && (state_q == S_DECODE);
  assign enable_execute   = !reset && (state_q == S_EXECUTE);
  assign enable_writeback = !reset && (state_q == S_WRITEBACK);
  assign enable_updatePC  = !reset && (state_q == S_UPDATE_PC);

  always_comb begin
    mem_state = MEM_IDLE;
    if (!reset) begin
      case (state_q)
        S_MEM_IND: mem_state = MEM_IND;
        S_MEM:     mem_state = is_store(op_q) ? MEM_WR : MEM_RD;
        default:   mem_state = MEM_IDLE;
      endcase
    end
  end

  assign br_taken    = br_taken_q;
  assign mem_err     = mem_err_q;
  assign instr_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lc3_sequencer.sv
// Bench for lc3_sequencer: instruction table with a reactive memory responder,
// plus reset-abort and counter-wrap sequences.
module tb_lc3_sequencer;
  import lc3_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IR;
  logic [2:0]  psr;
  logic        complete_instr, complete_data;
  logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
  logic [1:0]  mem_state;
  logic        br_taken, mem_err;
  logic [15:0] instr_count;
  logic [2:0]  dbg_state;

  logic        s_ef, s_ed, s_ee, s_ew, s_eu, s_br, s_err;
  logic [1:0]  s_ms;
  logic [3:0]  s_count;
  logic [2:0]  s_dbg;

  lc3_sequencer #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .IR(IR), .psr(psr),
    .complete_instr(complete_instr), .complete_data(complete_data),
    .enable_fetch(enable_fetch), .enable_decode(enable_decode),
    .enable_execute(enable_execute), .enable_writeback(enable_writeback),
    .enable_updatePC(enable_updatePC), .mem_state(mem_state),
    .br_taken(br_taken), .mem_err(mem_err), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  // Narrow-counter copy fed with identical stimulus, used for the wrap check.
  lc3_sequencer #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .IR(IR), .psr(psr),
    .complete_instr(complete_instr), .complete_data(complete_data),
    .enable_fetch(s_ef), .enable_decode(s_ed), .enable_execute(s_ee),
    .enable_writeback(s_ew), .enable_updatePC(s_eu), .mem_state(s_ms),
    .br_taken(s_br), .mem_err(s_err), .instr_count(s_count), .dbg_state(s_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ir;
    logic [2:0]  psr;
    logic [7:0]  di;      // fetch wait cycles before complete_instr
    logic [7:0]  dd;      // wait cycles per data access, FF = never
    logic        noise;   // hold completes high outside their wait states
    logic [31:0] trace;   // per-cycle codes of the first 8 cycles
    logic [7:0]  cycles;
    logic [3:0]  wb;
    logic        br;
    logic        err;
  } vec_t;

  vec_t        vecs[25];
  logic [47:0] exp_q[$];
  logic [15:0] exp_cnt;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] ir, input logic [2:0] p, input logic [7:0] di,
                              input logic [7:0] dd, input logic noise, input logic [31:0] trace,
                              input logic [7:0] cycles, input logic [3:0] wb, input logic br,
                              input logic err);
    vec_t v;
    v = '{ir, p, di, dd, noise, trace, cycles, wb, br, err};
    return v;
  endfunction

  // 1..5 = F/D/E/WB/UPC, 8/9/A = read/write/indirect wait, F = illegal combination.
  function automatic logic [3:0] enc();
    int n;
    logic [3:0] c;
    n = int'(enable_fetch) + int'(enable_decode) + int'(enable_execute)
      + int'(enable_writeback) + int'(enable_updatePC);
    c = 4'hF;
    if (n == 1 && mem_state == 2'd3) begin
      if (enable_fetch)          c = 4'h1;
      else if (enable_decode)    c = 4'h2;
      else if (enable_execute)   c = 4'h3;
      else if (enable_writeback) c = 4'h4;
      else                       c = 4'h5;
    end else if (n == 0 && mem_state != 2'd3) begin
      c = {2'b10, mem_state};
    end
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; complete_instr = 1'b0; complete_data = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_cnt = 16'd0;
  endtask

  task automatic run_instr(input vec_t v, input string tag);
    int cyc = 0, wb = 0, bad = 0, fwait = 0, dwait = 0;
    logic [31:0] trace = '0;
    logic [3:0]  code;
    logic [47:0] exp;
    logic        done = 1'b0, obs_br = 1'b0, obs_err = 1'b0;
    logic [1:0]  prev_ms = 2'd3;
    IR = v.ir; psr = v.psr;
    exp_q.push_back({v.trace, v.cycles, v.wb, v.br, v.err, 2'b00});
    while (!done && cyc < 64) begin
      @(negedge clk);
      if (cyc == 0) check($sformatf("%s.count", tag), instr_count, exp_cnt);
      code = enc();
      if (cyc < 8) trace[31-4*cyc -: 4] = code;
      if (code == 4'hF) bad++;
      if (enable_writeback) wb++;
      complete_instr = v.noise;
      complete_data  = v.noise;
      if (enable_fetch) begin
        complete_instr = (fwait == int'(v.di));
        fwait++;
      end
      if (mem_state != 2'd3) begin
        if (mem_state != prev_ms) dwait = 0;
        complete_data = (v.dd != 8'hFF) && (dwait == int'(v.dd));
        dwait++;
      end
      prev_ms = mem_state;
      cyc++;
      if (enable_updatePC) begin
        done = 1'b1; obs_br = br_taken; obs_err = mem_err;
      end
    end
    exp = exp_q.pop_front();
    check($sformatf("%s.retired", tag), done, 1'b1);
    if (done) begin
      check($sformatf("%s.trace", tag), trace, exp[47:16]);
      check($sformatf("%s.cycles", tag), cyc, exp[15:8]);
      check($sformatf("%s.wb", tag), wb, exp[7:4]);
      check($sformatf("%s.br_taken", tag), obs_br, exp[3]);
      check($sformatf("%s.mem_err", tag), obs_err, exp[2]);
      check($sformatf("%s.onehot", tag), bad, 0);
      exp_cnt = exp_cnt + 16'd1;
    end else begin
      do_reset();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s.enables", tag),
          {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC}, 5'b0);
    check($sformatf("%s.mem_state", tag), mem_state, 2'd3);
    check($sformatf("%s.br_taken", tag), br_taken, 1'b0);
    check($sformatf("%s.mem_err", tag), mem_err, 1'b0);
    check($sformatf("%s.count", tag), instr_count, 16'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "global time limit");
  end

  initial begin
    logic found;
    // Trace nibbles: F=1 D=2 E=3 WB=4 UPC=5, 8=read 9=write A=indirect.
    vecs[0]  = mk(16'h1042, 3'b000, 0, 0,     0, 32'h12345000, 5,  1, 0, 0);
    vecs[1]  = mk(16'h5042, 3'b000, 2, 0,     0, 32'h11123450, 7,  1, 0, 0);
    vecs[2]  = mk(16'h907F, 3'b000, 0, 0,     1, 32'h12345000, 5,  1, 0, 0);
    vecs[3]  = mk(16'hE005, 3'b000, 0, 0,     0, 32'h12345000, 5,  1, 0, 0);
    vecs[4]  = mk(16'h0403, 3'b010, 0, 0,     0, 32'h12350000, 4,  0, 1, 0);
    vecs[5]  = mk(16'h0403, 3'b100, 0, 0,     0, 32'h12350000, 4,  0, 0, 0);
    vecs[6]  = mk(16'h0E00, 3'b001, 0, 0,     0, 32'h12350000, 4,  0, 1, 0);
    vecs[7]  = mk(16'h0800, 3'b011, 0, 0,     0, 32'h12350000, 4,  0, 0, 0);
    vecs[8]  = mk(16'hC1C0, 3'b000, 0, 0,     0, 32'h12350000, 4,  0, 1, 0);
    vecs[9]  = mk(16'hF025, 3'b111, 0, 0,     0, 32'h12350000, 4,  0, 0, 0);
    vecs[10] = mk(16'h4800, 3'b111, 0, 0,     0, 32'h12350000, 4,  0, 0, 0);
    vecs[11] = mk(16'h8000, 3'b111, 0, 0,     0, 32'h12350000, 4,  0, 0, 0);
    vecs[12] = mk(16'hD000, 3'b111, 0, 0,     0, 32'h12350000, 4,  0, 0, 0);
    vecs[13] = mk(16'h2201, 3'b000, 0, 0,     0, 32'h12384500, 6,  1, 0, 0);
    vecs[14] = mk(16'h6041, 3'b000, 0, 1,     0, 32'h12388450, 7,  1, 0, 0);
    vecs[15] = mk(16'h3005, 3'b000, 0, 0,     0, 32'h12395000, 5,  0, 0, 0);
    vecs[16] = mk(16'h7041, 3'b000, 0, 2,     0, 32'h12399950, 7,  0, 0, 0);
    vecs[17] = mk(16'hA201, 3'b000, 0, 2,     0, 32'h123AAA88, 11, 1, 0, 0);
    vecs[18] = mk(16'hB201, 3'b000, 0, 0,     0, 32'h123A9500, 6,  0, 0, 0);
    vecs[19] = mk(16'hA201, 3'b000, 0, 0,     1, 32'h123A8450, 7,  1, 0, 0);
    vecs[20] = mk(16'h2201, 3'b000, 0, 15,    0, 32'h12388888, 21, 1, 0, 0);
    vecs[21] = mk(16'h3005, 3'b000, 0, 8'hFF, 0, 32'h12399999, 20, 0, 0, 1);
    vecs[22] = mk(16'h2201, 3'b000, 0, 8'hFF, 0, 32'h12388888, 20, 0, 0, 1);
    vecs[23] = mk(16'hA201, 3'b000, 0, 8'hFF, 0, 32'h123AAAAA, 20, 0, 0, 1);
    vecs[24] = mk(16'h1042, 3'b000, 0, 0,     0, 32'h12345000, 5,  1, 0, 1);

    reset = 1'b1; IR = 16'h0; psr = 3'b000;
    complete_instr = 1'b0; complete_data = 1'b0; exp_cnt = 16'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset.state", dbg_state, S_FETCH);
    reset = 1'b0;
    #1;
    check("release.fetch", enable_fetch, 1'b1);

    for (int i = 0; i < 25; i++) run_instr(vecs[i], $sformatf("v%0d", i));

    // Reset while waiting in MEM on a load that never completes.
    IR = 16'h2201; found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      complete_instr = enable_fetch; complete_data = 1'b0;
      if (mem_state == 2'd0) found = 1'b1;
    end
    check("rstmem.reached", found, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstmem");
    reset = 1'b0; exp_cnt = 16'd0;
    #1;
    check("rstmem.fetch", enable_fetch, 1'b1);
    run_instr(vecs[0], "after_rstmem");

    // Reset arriving during WRITEBACK must suppress the write and the retire.
    IR = 16'h1042; found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      complete_instr = enable_fetch; complete_data = 1'b0;
      if (enable_writeback) found = 1'b1;
    end
    check("rstwb.reached", found, 1'b1);
    reset = 1'b1;
    #1;
    check("rstwb.gated", enable_writeback, 1'b0);
    @(negedge clk);
    check_reset_outputs("rstwb");
    reset = 1'b0; exp_cnt = 16'd0;

    // Counter wrap: 4-bit copy goes 15 -> 0 while the 16-bit one reaches 16.
    for (int i = 0; i < 15; i++) run_instr(vecs[0], $sformatf("wrap%0d", i));
    @(negedge clk);
    check("wrap.small_full", s_count, 4'hF);
    run_instr(vecs[0], "wrap15");
    @(negedge clk);
    check("wrap.small_zero", s_count, 4'h0);
    check("wrap.big", instr_count, 16'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
